// File: rtl/pool_window_ctrl.sv
// Window sequencer for the 2x2 average-pooling stage: buffers one even row, assembles
// TL/TR/BL/BR windows on odd rows and tags each pooled result with its output coordinate.
module pool_window_ctrl #(
    parameter int FM_DEPTH  = 64,
    parameter int FM_WIDTH  = 32,
    parameter int FM_HEIGHT = 32,
    parameter int DW        = 16,
    localparam int CW  = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)    : 1,
    localparam int RW  = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT)   : 1,
    localparam int OCW = (FM_WIDTH  > 2) ? $clog2(FM_WIDTH/2)  : 1,
    localparam int ORW = (FM_HEIGHT > 2) ? $clog2(FM_HEIGHT/2) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [DW-1:0]  in_data_i [FM_DEPTH],
    output logic           pool_valid_o,
    output logic [DW-1:0]  pool_win_o [FM_DEPTH][4],
    output logic           out_valid_o,
    output logic [ORW-1:0] out_row_o,
    output logic [OCW-1:0] out_col_o,
    output logic           busy_o,
    output logic           frame_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN1 = 2'd2,
        ST_DRAIN2 = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [DW-1:0]  linebuf_q [FM_WIDTH][FM_DEPTH];
    logic [DW-1:0]  hold_q [FM_DEPTH];
    logic [DW-1:0]  pool_win_q [FM_DEPTH][4];
    logic           in_ready_q, busy_q, pool_valid_q, out_valid_q, frame_done_q;
    logic [ORW-1:0] win_row_q, out_row_q;
    logic [OCW-1:0] win_col_q, out_col_q;

    logic           accept_s, col_last_s, row_last_s, last_pix_s, win_s;
    logic [CW-1:0]  col_even_s;

    // in_ready_q mirrors "state is RUN", so accept needs no extra decode
    assign accept_s   = in_valid_i & in_ready_q;
    assign col_last_s = (col_q == CW'(FM_WIDTH - 1));
    assign row_last_s = (row_q == RW'(FM_HEIGHT - 1));
    assign last_pix_s = accept_s & col_last_s & row_last_s;
    assign win_s      = accept_s & row_q[0] & col_q[0];
    assign col_even_s = col_q & ~(CW'(1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_RUN; else state_d = ST_IDLE;
            ST_RUN:    if (last_pix_s) state_d = ST_DRAIN1; else state_d = ST_RUN;
            ST_DRAIN1: state_d = ST_DRAIN2;
            ST_DRAIN2: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_q <= '0;
                row_q <= row_last_s ? RW'(0) : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Line buffer and odd-row hold register; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept_s && !row_q[0]) begin
            linebuf_q[col_q] <= in_data_i;
        end
        if (accept_s && row_q[0] && !col_q[0]) begin
            hold_q <= in_data_i;
        end
    end

    // Window launch, one-cycle pooling delay tag, and status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pool_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            for (int ch = 0; ch < FM_DEPTH; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    pool_win_q[ch][k] <= '0;
                end
            end
        end else begin
            pool_valid_q <= win_s;
            out_valid_q  <= pool_valid_q;
            frame_done_q <= (state_q == ST_DRAIN2);
            in_ready_q   <= (state_d == ST_RUN);
            busy_q       <= (state_d != ST_IDLE);
            if (win_s) begin
                win_row_q <= ORW'(row_q >> 1);
                win_col_q <= OCW'(col_q >> 1);
                for (int ch = 0; ch < FM_DEPTH; ch++) begin
                    pool_win_q[ch][0] <= linebuf_q[col_even_s][ch];
                    pool_win_q[ch][1] <= linebuf_q[col_q][ch];
                    pool_win_q[ch][2] <= hold_q[ch];
                    pool_win_q[ch][3] <= in_data_i[ch];
                end
            end
            if (pool_valid_q) begin
                out_row_q <= win_row_q;
                out_col_q <= win_col_q;
            end
        end
    end

    assign in_ready_o   = in_ready_q;
    assign busy_o       = busy_q;
    assign pool_valid_o = pool_valid_q;
    assign pool_win_o   = pool_win_q;
    assign out_valid_o  = out_valid_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl: raster-level reference model compared every cycle,
// plus literal expectations for the 4x4 pattern frame.
module tb_pool_window_ctrl;
    localparam int D  = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i [D];
    logic          pool_valid_o;
    logic [DW-1:0] pool_win_o [D][4];
    logic          out_valid_o;
    logic [0:0]    out_row_o;
    logic [0:0]    out_col_o;
    logic          busy_o;
    logic          frame_done_o;

    pool_window_ctrl #(.FM_DEPTH(D), .FM_WIDTH(W), .FM_HEIGHT(H), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .pool_valid_o(pool_valid_o),
        .pool_win_o(pool_win_o), .out_valid_o(out_valid_o), .out_row_o(out_row_o),
        .out_col_o(out_col_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (raster/timeline level) ----------------
    int m_mode = 0;          // 0 idle, 1 accepting pixels, 2 draining
    int m_dcnt = 0;
    int m_beat = 0;
    int pix [H][W][D];
    int mr, mc;
    bit e_ready = 0, e_busy = 0, e_pv = 0, e_ov = 0, e_fd = 0, e_pv_last = 0, e_ov_last = 0;
    int e_win [D][4];
    int e_wr = 0, e_wc = 0, e_orow = 0, e_ocol = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode = 0; m_dcnt = 0; m_beat = 0;
            e_ready = 0; e_busy = 0; e_pv = 0; e_ov = 0; e_fd = 0;
            e_pv_last = 0; e_ov_last = 0;
            e_wr = 0; e_wc = 0; e_orow = 0; e_ocol = 0;
            for (int ch = 0; ch < D; ch++)
                for (int k = 0; k < 4; k++) e_win[ch][k] = 0;
        end else begin
            e_fd = e_ov && e_ov_last;
            e_ov = e_pv;
            e_ov_last = e_pv_last;
            if (e_pv) begin
                e_orow = e_wr;
                e_ocol = e_wc;
            end
            e_pv = 0;
            e_pv_last = 0;
            case (m_mode)
                0: if (start_i) begin m_mode = 1; m_beat = 0; end
                1: if (in_valid_i) begin
                    mr = m_beat / W;
                    mc = m_beat % W;
                    for (int ch = 0; ch < D; ch++) pix[mr][mc][ch] = int'(in_data_i[ch]);
                    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                        e_pv = 1;
                        e_pv_last = (m_beat == W*H - 1);
                        e_wr = mr / 2;
                        e_wc = mc / 2;
                        for (int ch = 0; ch < D; ch++) begin
                            e_win[ch][0] = pix[mr-1][mc-1][ch];
                            e_win[ch][1] = pix[mr-1][mc][ch];
                            e_win[ch][2] = pix[mr][mc-1][ch];
                            e_win[ch][3] = pix[mr][mc][ch];
                        end
                    end
                    m_beat++;
                    if (m_beat == W*H) begin m_mode = 2; m_dcnt = 2; end
                end
                default: begin
                    m_dcnt--;
                    if (m_dcnt == 0) m_mode = 0;
                end
            endcase
            e_ready = (m_mode == 1);
            e_busy  = (m_mode != 0);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", int'(in_ready_o), int'(e_ready));
            chk("busy", int'(busy_o), int'(e_busy));
            chk("pool_valid", int'(pool_valid_o), int'(e_pv));
            chk("out_valid", int'(out_valid_o), int'(e_ov));
            chk("frame_done", int'(frame_done_o), int'(e_fd));
            chk("out_row", int'(out_row_o), e_orow);
            chk("out_col", int'(out_col_o), e_ocol);
            for (int ch = 0; ch < D; ch++)
                for (int k = 0; k < 4; k++)
                    chk($sformatf("pool_win[%0d][%0d]", ch, k), int'(pool_win_o[ch][k]), e_win[ch][k]);
        end
    end

    // ---------------- output logger ----------------
    int n_pv = 0, n_ov = 0, n_fd = 0;
    int log_win [16][D][4];
    int log_row [16];
    int log_col [16];

    always @(negedge clk) begin
        if (pool_valid_o && n_pv < 16) begin
            for (int ch = 0; ch < D; ch++)
                for (int k = 0; k < 4; k++) log_win[n_pv][ch][k] = int'(pool_win_o[ch][k]);
        end
        if (pool_valid_o) n_pv++;
        if (out_valid_o && n_ov < 16) begin
            log_row[n_ov] = int'(out_row_o);
            log_col[n_ov] = int'(out_col_o);
        end
        if (out_valid_o) n_ov++;
        if (frame_done_o) n_fd++;
    end

    task automatic clear_logs();
        n_pv = 0; n_ov = 0; n_fd = 0;
    endtask

    // ---------------- stimulus ----------------
    // gap: 0 = in_valid always, 1 = every other cycle, 2 = random
    task automatic send_frame(input int gap, input bit rnd, input int abort_at,
                              input bit poke, input int post);
        int b = 0;
        int cyc = 0;
        bit acc;
        bit aborted = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (b < W*H && cyc < 400 && !aborted) begin
            case (gap)
                0: in_valid_i = 1'b1;
                1: in_valid_i = (cyc % 2 == 0);
                default: in_valid_i = 1'($urandom_range(0, 1));
            endcase
            for (int ch = 0; ch < D; ch++)
                in_data_i[ch] = rnd ? DW'($urandom_range(0, 65535))
                                    : DW'(100*ch + 4*(b / W) + (b % W));
            if (poke) start_i = ($urandom_range(0, 3) == 0);
            acc = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            cyc++;
            if (acc) b++;
            if (b == abort_at) begin
                aborted = 1;
                in_valid_i = 1'b0;
                start_i = 1'b0;
                rstn = 1'b0;
                #6;
                chk("rst_pool_valid", int'(pool_valid_o), 0);
                chk("rst_out_valid", int'(out_valid_o), 0);
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_in_ready", int'(in_ready_o), 0);
                chk("rst_frame_done", int'(frame_done_o), 0);
                @(posedge clk); #1;
                rstn = 1'b1;
            end
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        if (!aborted) begin
            chk("frame_beats_accepted", b, W*H);
            repeat (post) begin @(posedge clk); #1; end
        end
    endtask

    // Pattern frame: window (wr,wc) ch c = 100c + {4*2wr+2wc, +1, +4, +5}
    task automatic chk_pattern(input string tag, input int base);
        int tl;
        for (int i = 0; i < 4; i++) begin
            tl = 8*(i / 2) + 2*(i % 2);
            for (int ch = 0; ch < D; ch++) begin
                chk($sformatf("%s_w%0d_c%0d_tl", tag, i, ch), log_win[base+i][ch][0], 100*ch + tl);
                chk($sformatf("%s_w%0d_c%0d_tr", tag, i, ch), log_win[base+i][ch][1], 100*ch + tl + 1);
                chk($sformatf("%s_w%0d_c%0d_bl", tag, i, ch), log_win[base+i][ch][2], 100*ch + tl + 4);
                chk($sformatf("%s_w%0d_c%0d_br", tag, i, ch), log_win[base+i][ch][3], 100*ch + tl + 5);
            end
            chk($sformatf("%s_row%0d", tag, i), log_row[base+i], i / 2);
            chk($sformatf("%s_col%0d", tag, i), log_col[base+i], i % 2);
        end
    endtask

    initial begin
        for (int ch = 0; ch < D; ch++) in_data_i[ch] = '0;
        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", int'(in_ready_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_pool_win00", int'(pool_win_o[0][0]), 0);
        chk("reset_out_row", int'(out_row_o), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: continuous stream
        clear_logs();
        send_frame(0, 0, -1, 0, 6);
        chk("t1_pool_valid_count", n_pv, 4);
        chk("t1_frame_done_count", n_fd, 1);
        chk("t1_first_tl", log_win[0][0][0], 0);
        chk("t1_first_br", log_win[0][0][3], 5);
        chk("t1_last_tl", log_win[3][0][0], 10);
        chk("t1_last_br", log_win[3][0][3], 15);
        chk_pattern("t1", 0);

        // 2: in_valid every other cycle
        clear_logs();
        send_frame(1, 0, -1, 0, 6);
        chk("t2_pool_valid_count", n_pv, 4);
        chk("t2_frame_done_count", n_fd, 1);
        chk_pattern("t2", 0);

        // 3: ch1 average of first window
        chk("t3_ch1_avg", (log_win[0][1][0] + log_win[0][1][1] +
                           log_win[0][1][2] + log_win[0][1][3]) >> 2, 102);

        // 4: in_valid in IDLE, start pokes during RUN
        clear_logs();
        in_valid_i = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t4_idle_in_ready", int'(in_ready_o), 0);
        end
        in_valid_i = 1'b0;
        chk("t4_idle_no_pool", n_pv, 0);
        send_frame(2, 0, -1, 1, 6);
        chk("t4_pool_valid_count", n_pv, 4);
        chk("t4_frame_done_count", n_fd, 1);
        chk_pattern("t4", 0);

        // 5: reset mid-frame, then a clean frame
        clear_logs();
        send_frame(0, 0, 10, 0, 0);
        chk("t5_no_frame_done", n_fd, 0);
        clear_logs();
        send_frame(0, 0, -1, 0, 6);
        chk("t5_pool_valid_count", n_pv, 4);
        chk("t5_frame_done_count", n_fd, 1);
        chk_pattern("t5", 0);

        // 6: back-to-back, start on the IDLE-return cycle
        clear_logs();
        send_frame(0, 0, -1, 0, 2);
        send_frame(0, 0, -1, 0, 6);
        chk("t6_pool_valid_count", n_pv, 8);
        chk("t6_frame_done_count", n_fd, 2);
        chk_pattern("t6a", 0);
        chk_pattern("t6b", 4);

        // 7: random data and random gaps
        for (int f = 0; f < 4; f++) begin
            clear_logs();
            send_frame(2, 1, -1, f % 2, 6);
            chk("t7_pool_valid_count", n_pv, 4);
            chk("t7_frame_done_count", n_fd, 1);
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
